// File: rtl/ycbcr_convert_pipe.sv
// Three-stage RGB -> YCbCr converter with per-component clamping,
// sideband carry, frame-latched mode and per-frame clip counting.
module ycbcr_convert_pipe #(
    parameter int DATA_W    = 8,
    parameter int SIDE_W    = 22,
    parameter int CLIPCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      r,
    input  logic [DATA_W-1:0]      g,
    input  logic [DATA_W-1:0]      b,
    input  logic [SIDE_W-1:0]      in_side,
    output logic                   out_valid,
    output logic [3*DATA_W-1:0]    ycbcr,
    output logic [SIDE_W-1:0]      out_side,
    output logic [CLIPCNT_W-1:0]   clip_count
);

    localparam int SW = DATA_W + 13;
    localparam int SH = DATA_W - 8;

    typedef logic signed [SW-1:0] acc_t;

    typedef enum logic [1:0] {
        M_709L = 2'd0,
        M_601L = 2'd1,
        M_601F = 2'd2,
        M_BYP  = 2'd3
    } mode_e;

    localparam acc_t Y_OFF = acc_t'((16 << SH) << 10);
    localparam acc_t C_OFF = acc_t'((128 << SH) << 10);
    localparam acc_t RND   = acc_t'(512);
    localparam acc_t Y_LO  = acc_t'(16 << SH);
    localparam acc_t Y_HI  = acc_t'(235 << SH);
    localparam acc_t C_LO  = acc_t'(16 << SH);
    localparam acc_t C_HI  = acc_t'(240 << SH);
    localparam acc_t F_HI  = acc_t'((1 << DATA_W) - 1);

    mode_e mode_q;
    mode_e act_mode;

    // A pixel arriving with frame_start already sees the new mode.
    assign act_mode = frame_start ? mode_e'(mode) : mode_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= M_709L;
        end else if (frame_start) begin
            mode_q <= mode_e'(mode);
        end
    end

    logic signed [11:0] coef_d [9];

    always_comb begin
        coef_d = '{default: 12'sd0};
        unique case (act_mode)
            M_709L: coef_d = '{12'sd187, 12'sd629, 12'sd63,
                               -12'sd103, -12'sd347, 12'sd450,
                               12'sd450, -12'sd409, -12'sd41};
            M_601L: coef_d = '{12'sd263, 12'sd516, 12'sd100,
                               -12'sd152, -12'sd298, 12'sd450,
                               12'sd450, -12'sd377, -12'sd73};
            M_601F: coef_d = '{12'sd306, 12'sd601, 12'sd117,
                               -12'sd173, -12'sd339, 12'sd512,
                               12'sd512, -12'sd429, -12'sd83};
            M_BYP:  coef_d = '{default: 12'sd0};
        endcase
    end

    acc_t comp [3];

    assign comp[0] = acc_t'({1'b0, r});
    assign comp[1] = acc_t'({1'b0, g});
    assign comp[2] = acc_t'({1'b0, b});

    acc_t prod_d [9];

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) begin
                prod_d[c*3+k] = acc_t'(coef_d[c*3+k]) * comp[k];
            end
        end
    end

    // Stage 1: products, with the mode travelling alongside the pixel.
    acc_t                prod_q [9];
    logic                v1_q;
    logic [SIDE_W-1:0]   side1_q;
    mode_e               mode1_q;
    logic [3*DATA_W-1:0] rgb1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
            v1_q    <= 1'b0;
            side1_q <= '0;
            mode1_q <= M_709L;
            rgb1_q  <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= prod_d[i];
            end
            v1_q    <= in_valid;
            side1_q <= in_side;
            mode1_q <= act_mode;
            rgb1_q  <= {r, g, b};
        end
    end

    acc_t sum_d [3];

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum_d[c] = prod_q[c*3] + prod_q[c*3+1] + prod_q[c*3+2]
                     + C_OFF + RND;
        end
        sum_d[0] = prod_q[0] + prod_q[1] + prod_q[2] + RND
                 + ((mode1_q == M_601F) ? acc_t'(0) : Y_OFF);
    end

    // Stage 2: offset and rounded sums.
    acc_t                sum_q [3];
    logic                v2_q;
    logic [SIDE_W-1:0]   side2_q;
    mode_e               mode2_q;
    logic [3*DATA_W-1:0] rgb2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
            end
            v2_q    <= 1'b0;
            side2_q <= '0;
            mode2_q <= M_709L;
            rgb2_q  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= sum_d[i];
            end
            v2_q    <= v1_q;
            side2_q <= side1_q;
            mode2_q <= mode1_q;
            rgb2_q  <= rgb1_q;
        end
    end

    logic [DATA_W-1:0]   res_d [3];
    logic                clip_d;
    logic [3*DATA_W-1:0] ycbcr_d;

    always_comb begin
        acc_t sh_v;
        acc_t lo_v;
        acc_t hi_v;
        logic full_v;
        full_v = (mode2_q == M_601F);
        clip_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sh_v = sum_q[c] >>> 10;
            lo_v = full_v ? acc_t'(0) : ((c == 0) ? Y_LO : C_LO);
            hi_v = full_v ? F_HI : ((c == 0) ? Y_HI : C_HI);
            if (sh_v < lo_v) begin
                sh_v   = lo_v;
                clip_d = 1'b1;
            end else if (sh_v > hi_v) begin
                sh_v   = hi_v;
                clip_d = 1'b1;
            end
            res_d[c] = sh_v[DATA_W-1:0];
        end
        ycbcr_d = {res_d[0], res_d[1], res_d[2]};
        if (mode2_q == M_BYP) begin
            ycbcr_d = rgb2_q;
            clip_d  = 1'b0;
        end
    end

    // Stage 3: output registers; pixel data holds across invalid cycles.
    logic clip_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_side  <= '0;
            ycbcr     <= '0;
            clip_q    <= 1'b0;
        end else begin
            out_valid <= v2_q;
            out_side  <= side2_q;
            clip_q    <= v2_q & clip_d;
            if (v2_q) begin
                ycbcr <= ycbcr_d;
            end
        end
    end

    logic [CLIPCNT_W-1:0] cnt_q;
    logic [CLIPCNT_W-1:0] cnt_d;

    // A clip presented on the frame_start cycle still belongs to the closing frame.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && clip_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            clip_count <= '0;
        end else if (frame_start) begin
            cnt_q      <= '0;
            clip_count <= cnt_d;
        end else begin
            cnt_q      <= cnt_d;
        end
    end

endmodule
